// File: rtl/line_editor_pkg.sv
// line_editor_pkg: shared state encoding, ASCII constants and helpers for the line editor.
package line_editor_pkg;
  typedef enum logic [1:0] {EDIT, COMMIT, CLEAR} state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MIN   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;
  function automatic logic printable(input logic [7:0] c);
    return c >= ASCII_MIN && c <= ASCII_MAX;
  endfunction
endpackage

// File: rtl/line_store.sv
// line_store: byte register array with one write port, clear-all, registered read and flat view.
module line_store
  import line_editor_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          clr,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  output logic [8*N-1:0] flat
);
  logic [7:0] mem [N];
  // The read samples the array before this edge's write lands, so same-address reads see the old byte.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= ASCII_SPACE;
      rdata <= ASCII_SPACE;
    end else begin
      rdata <= mem[raddr];
      if (clr) for (int i = 0; i < N; i++) mem[i] <= ASCII_SPACE;
      else if (we) mem[waddr] <= wdata;
    end
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign flat[8*g +: 8] = mem[g];
  end
endmodule

// File: rtl/line_editor.sv
// line_editor: edits a command line from keyboard strobes and hands the frozen line downstream.
module line_editor
  import line_editor_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int ADDR_W    = $clog2(MAX_CHARS)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   key_pressed,
  input  logic                   bksp_pressed,
  input  logic                   enter_pressed,
  input  logic [15:0]            character,
  input  logic [ADDR_W-1:0]      disp_addr,
  output logic [7:0]             disp_char,
  output logic [ADDR_W:0]        cursor,
  output logic                   key_rejected,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [ADDR_W:0]        instr_len,
  output logic [8*MAX_CHARS-1:0] instr_chars
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(MAX_CHARS);
  state_t state, state_nx;
  logic edit, key_ok, do_key, do_bk, we, clr, rej_nx;
  logic [ADDR_W-1:0] waddr;
  logic [7:0] wdata;
  logic [ADDR_W:0] cursor_nx, len_nx;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= EDIT;
    else state <= state_nx;
  always_comb
    state_nx = state == EDIT   ? (enter_pressed && |cursor ? COMMIT : EDIT) :
               state == COMMIT ? (instr_ready ? CLEAR : COMMIT) : EDIT;
  // Priority enter > bksp > key; anything that loses arbitration or is illegal is reported.
  always_comb begin
    edit      = state == EDIT;
    key_ok    = printable(character[7:0]) && cursor != FULL;
    do_key    = edit && !enter_pressed && !bksp_pressed && key_pressed && key_ok;
    do_bk     = edit && !enter_pressed && bksp_pressed && |cursor;
    we        = do_key || do_bk;
    waddr     = do_key ? cursor[ADDR_W-1:0] : cursor[ADDR_W-1:0] - 1'b1;
    wdata     = do_key ? character[7:0] : ASCII_SPACE;
    clr       = state == CLEAR;
    cursor_nx = clr ? '0 : do_key ? cursor + 1'b1 : do_bk ? cursor - 1'b1 : cursor;
    len_nx    = edit && enter_pressed && |cursor ? cursor : instr_len;
    rej_nx    = !edit         ? key_pressed || bksp_pressed || enter_pressed :
                enter_pressed ? key_pressed || bksp_pressed :
                bksp_pressed  ? key_pressed || ~|cursor :
                key_pressed && !key_ok;
  end
  assign instr_valid = state == COMMIT;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      cursor       <= '0;
      key_rejected <= 1'b0;
      instr_len    <= '0;
    end else begin
      cursor       <= cursor_nx;
      key_rejected <= rej_nx;
      instr_len    <= len_nx;
    end
  line_store #(.N(MAX_CHARS), .AW(ADDR_W)) u_store (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .clr   (clr),
    .raddr (disp_addr),
    .rdata (disp_char),
    .flat  (instr_chars)
  );
endmodule

// File: tb/tb_line_editor.sv
// tb_line_editor: directed stimulus with a queue-based line model checked every cycle.
module tb_line_editor;
  localparam int N  = 32;
  localparam int AW = 5;
  logic clk_in = 0, rst_n_in = 0;
  logic key_pressed = 0, bksp_pressed = 0, enter_pressed = 0, instr_ready = 0;
  logic [15:0] character = 0;
  logic [AW-1:0] disp_addr = 0;
  logic [7:0] disp_char;
  logic [AW:0] cursor, instr_len;
  logic key_rejected, instr_valid;
  logic [8*N-1:0] instr_chars;
  int total = 0, bad = 0;
  logic [7:0] line [$];
  int mstate, mlen;
  logic mrej;
  logic [7:0] mdisp;
  logic run = 0;

  always #5 clk_in = ~clk_in;

  line_editor #(.MAX_CHARS(N), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .key_pressed(key_pressed),
    .bksp_pressed(bksp_pressed), .enter_pressed(enter_pressed), .character(character),
    .disp_addr(disp_addr), .disp_char(disp_char), .cursor(cursor),
    .key_rejected(key_rejected), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_len(instr_len), .instr_chars(instr_chars)
  );

  function automatic logic [7:0] mbyte(int i);
    return i < line.size() ? line[i] : 8'h20;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    line.delete();
    mstate = 0;
    mlen = 0;
    mrej = 0;
    mdisp = 8'h20;
  endtask

  // Line semantics: a queue of typed characters; 0 edit, 1 committed, 2 clearing.
  task automatic model_step();
    logic [7:0] c;
    logic kok;
    c = character[7:0];
    mdisp = mbyte(int'(disp_addr));
    kok = c >= 8'h20 && c <= 8'h7E && line.size() < N;
    mrej = 0;
    case (mstate)
      0: if (enter_pressed) begin
           if (line.size() > 0) begin mstate = 1; mlen = line.size(); end
           mrej = bksp_pressed || key_pressed;
         end else if (bksp_pressed) begin
           if (line.size() > 0) void'(line.pop_back()); else mrej = 1;
           if (key_pressed) mrej = 1;
         end else if (key_pressed) begin
           if (kok) line.push_back(c); else mrej = 1;
         end
      1: begin
           mrej = key_pressed || bksp_pressed || enter_pressed;
           if (instr_ready) mstate = 2;
         end
      default: begin
           mrej = key_pressed || bksp_pressed || enter_pressed;
           line.delete();
           mstate = 0;
         end
    endcase
  endtask

  task automatic step(logic k, logic b, logic e, logic [15:0] ch);
    key_pressed = k;
    bksp_pressed = b;
    enter_pressed = e;
    character = ch;
    @(posedge clk_in);
    model_step();
    #1;
    key_pressed = 0;
    bksp_pressed = 0;
    enter_pressed = 0;
    @(negedge clk_in);
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0);
  endtask

  task automatic typ(logic [15:0] ch);
    step(1, 0, 0, ch);
  endtask

  task automatic bk();
    step(0, 1, 0, 16'h0);
  endtask

  task automatic sweep_spaces(string nm);
    for (int i = 0; i < N; i++) begin
      disp_addr = AW'(i);
      idle();
      chk(nm, disp_char, 8'h20);
    end
  endtask

  always @(negedge clk_in) begin
    logic [8*N-1:0] ev;
    if (run && rst_n_in) begin
      chk("cyc_cursor", cursor, line.size());
      chk("cyc_valid", instr_valid, mstate == 1);
      chk("cyc_rej", key_rejected, mrej);
      chk("cyc_len", instr_len, mlen);
      chk("cyc_disp", disp_char, mdisp);
      if (mstate == 1) begin
        for (int i = 0; i < N; i++) ev[8*i +: 8] = mbyte(i);
        total++;
        if (instr_chars !== ev) begin
          bad++;
          $display("FAIL cyc_chars: got %h want %h", instr_chars, ev);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    run = 1;
    chk("rst_cursor", cursor, 0);
    chk("rst_disp", disp_char, 8'h20);
    chk("rst_valid", instr_valid, 0);
    chk("rst_len", instr_len, 0);
    chk("rst_rej", key_rejected, 0);
    typ(16'h68);
    typ(16'h69);
    chk("hi_cursor", cursor, 2);
    chk("hi_norej", key_rejected, 0);
    disp_addr = 0;
    idle();
    chk("hi_d0", disp_char, 8'h68);
    disp_addr = 1;
    idle();
    chk("hi_d1", disp_char, 8'h69);
    bk();
    bk();
    typ(16'h61);
    typ(16'h62);
    bk();
    typ(16'h63);
    step(0, 0, 1, 16'h0);
    chk("ent_valid", instr_valid, 1);
    chk("ent_len", instr_len, 2);
    chk("ent_chars", instr_chars[15:0], 16'h6361);
    repeat (4) idle();
    chk("hold_valid", instr_valid, 1);
    instr_ready = 1;
    idle();
    instr_ready = 0;
    chk("hs_valid", instr_valid, 0);
    idle();
    chk("clr_cursor", cursor, 0);
    sweep_spaces("clr_buf");
    bk();
    chk("bk0_rej", key_rejected, 1);
    chk("bk0_cursor", cursor, 0);
    step(0, 0, 1, 16'h0);
    chk("ent0_valid", instr_valid, 0);
    chk("ent0_rej", key_rejected, 0);
    typ(16'h000A);
    chk("lf_rej", key_rejected, 1);
    typ(16'h007F);
    chk("del_rej", key_rejected, 1);
    typ(16'hAB20);
    chk("hi_byte_cursor", cursor, 1);
    chk("hi_byte_rej", key_rejected, 0);
    bk();
    for (int i = 0; i < N; i++) typ(16'h41 + 16'(i % 26));
    chk("full_cursor", cursor, 32);
    typ(16'h23);
    chk("over_rej", key_rejected, 1);
    chk("over_cursor", cursor, 32);
    disp_addr = 5'd31;
    idle();
    chk("over_buf31", disp_char, 8'h46);
    for (int i = 0; i < N; i++) bk();
    chk("drain_cursor", cursor, 0);
    typ(16'h78);
    typ(16'h79);
    typ(16'h7A);
    step(1, 0, 1, 16'h41);
    chk("ek_valid", instr_valid, 1);
    chk("ek_len", instr_len, 3);
    chk("ek_rej", key_rejected, 1);
    chk("ek_chars", instr_chars[23:0], 24'h7A7978);
    typ(16'h51);
    chk("cm_rej", key_rejected, 1);
    chk("cm_chars", instr_chars[31:0], 32'h207A7978);
    typ(16'h52);
    chk("cm_rej2", key_rejected, 1);
    instr_ready = 1;
    idle();
    instr_ready = 0;
    typ(16'h53);
    chk("clr_rej", key_rejected, 1);
    chk("clr_cursor2", cursor, 0);
    typ(16'h70);
    typ(16'h71);
    step(0, 0, 1, 16'h0);
    chk("ar_valid_pre", instr_valid, 1);
    #2 rst_n_in = 0;
    #1 chk("ar_valid", instr_valid, 0);
    chk("ar_cursor", cursor, 0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1;
    idle();
    chk("ar_edit_valid", instr_valid, 0);
    sweep_spaces("ar_buf");
    typ(16'h6B);
    chk("ar_edit_cursor", cursor, 1);
    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_editor.md
# line_editor

Controller that turns the keyboard decoder's single-cycle strobes (`key_pressed`, `bksp_pressed`, `enter_pressed`, `character`) into an edited command line. It keeps a fixed-length character buffer with a cursor and applies backspace. On enter, it freezes the line and hands it to the downstream instruction parser over a valid/ready handshake. It also gives the text renderer a registered read port so the line can be displayed while it is typed.

## Interface
- `MAX_CHARS`, 32, line capacity in characters; a power of two, at least 4.
- `ADDR_W`, $clog2(MAX_CHARS), width of the cursor and read address.
- `clk_in`  in  1  system clock; all logic is on posedge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `key_pressed`  in  1  one-cycle strobe: printable key, with code on `character`.
- `bksp_pressed`  in  1  one-cycle strobe: backspace.
- `enter_pressed`  in  1  one-cycle strobe: enter.
- `character`  in  16  ASCII code in bits [7:0]; bits [15:8] are ignored.
- `disp_addr`  in  ADDR_W  display read address.
- `disp_char`  out  8  buffer byte at `disp_addr`, registered.
- `cursor`  out  ADDR_W+1  current line length, 0..MAX_CHARS.
- `key_rejected`  out  1  one-cycle pulse when an input strobe is dropped.
- `instr_valid`  out  1  committed line available downstream.
- `instr_ready`  in  1  downstream accepts the line.
- `instr_len`  out  ADDR_W+1  committed length, 1..MAX_CHARS.
- `instr_chars`  out  8*MAX_CHARS  committed line; char i is in [8i+7:8i]; unused positions hold 0x20.

## Operation
- FSM states:
  - EDIT: accepts editing strobes.
  - COMMIT: `instr_valid`=1, buffer frozen.
  - CLEAR: one cycle; fills the buffer with 0x20 and sets cursor to 0, then returns to EDIT.
- Strobe priority when several are high in the same cycle: enter > bksp > key. Each lower-priority strobe that is dropped causes a `key_rejected` pulse.
- Behaviour in EDIT:
  - key:
    - Accepted if 0x20 ≤ char ≤ 0x7E and cursor < MAX_CHARS. Then buf[cursor] ← char and cursor+1.
    - Otherwise it is rejected, and buffer and cursor are unchanged.
  - bksp:
    - If cursor > 0: buf[cursor-1] ← 0x20 and cursor−1.
    - If cursor = 0: rejected.
  - enter:
    - If cursor > 0: `instr_len` ← cursor and go to COMMIT.
    - If cursor = 0: ignored silently (no pulse).
- Behaviour in COMMIT:
  - `instr_chars` is driven directly from the frozen buffer and is stable while valid.
  - Every strobe is rejected.
  - `instr_valid` && `instr_ready` → CLEAR.
- Behaviour in CLEAR:
  - Every strobe is rejected.
- Cursor arithmetic is unsigned, ADDR_W+1 bits. It never wraps and is saturated by the rules above.
- Reset values:
  - State EDIT, cursor 0, buffer all 0x20.
  - `instr_valid` 0, `instr_len` 0, `key_rejected` 0, `disp_char` 0x20.
- Reset asserted mid-COMMIT drops the line without a handshake.

## Timing
- An accepted key/bksp changes buffer and cursor at the next posedge, so `cursor` updates one cycle after the strobe.
- Enter strobe at cycle n → `instr_valid` high from cycle n+1.
- Handshake completes on the edge where valid && ready → CLEAR at n+k+1 → EDIT with cursor 0 at n+k+2.
- A strobe in the CLEAR cycle is rejected.
- `instr_valid` never drops without a handshake.
- `ready` may be high before `valid`; no combinational path from `ready` to `valid`.
- `key_rejected` pulses in the cycle after the offending strobe.
- `disp_char` has one-cycle latency from `disp_addr`. A write and a read of the same address in the same cycle return the old value.

## Structure
- Package `line_editor_pkg` holds:
  - the state enum (EDIT, COMMIT, CLEAR);
  - constants ASCII_SPACE=8'h20, ASCII_MIN=8'h20, ASCII_MAX=8'h7E.
- Sub-module `line_store`:
  - register array of MAX_CHARS bytes;
  - one write port and a clear-all;
  - registered display read port;
  - packed flat output for `instr_chars`.
- The FSM, priority resolution and cursor stay in the top module.

## Test plan
- Reset, then key strobes 'h','i' (0x68, 0x69) → cursor 2, `disp_char`@0 = 0x68 and @1 = 0x69, no `key_rejected`.
- Type "ab", bksp, 'c', enter with `instr_ready`=0 for 5 cycles, then 1:
  - `instr_valid` rises the cycle after enter and holds 5 cycles;
  - `instr_len`=2 and `instr_chars`[15:0]=0x6361;
  - two cycles after the handshake, cursor=0 and every buffer byte is 0x20.
- With MAX_CHARS=32, send 33 keys → cursor saturates at 32; the 33rd key gives one `key_rejected` pulse and buf[31] is unchanged.
- Boundary cases:
  - bksp at cursor 0 → one `key_rejected` pulse, cursor 0;
  - enter at cursor 0 → no `instr_valid` and no pulse;
  - key 0x0A → rejected.
- Enter and key in the same cycle with cursor 3 → COMMIT with `instr_len`=3, one `key_rejected`. Keys during COMMIT are each rejected and the committed data is unchanged.
- `rst_n_in` asserted while in COMMIT → `instr_valid` falls immediately (asynchronous). After release: state EDIT, cursor 0, buffer all spaces.
